// File: rtl/sram_rr_arb_ctrl.sv
// Single-port SRAM controller: zero-fills the array after reset or clear_req,
// then round-robin arbitrates two requesters. Optional macro SRAM_RR_ARB_CONFLICT_CNT_EN.
//
// state | meaning
// WAIT  | idle for one cycle after reset
// INIT  | zero-filling the array, one address per cycle
// RUN   | array ready, arbitration active
module sram_rr_arb_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 13
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear_req,
  output logic              init_done,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_wmode,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_wmode,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_data,
  output logic              mem_en,
  output logic              mem_wmode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef SRAM_RR_ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0]       conflict_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] init_cnt_q;
  logic              rr_q;
  logic [1:0]        resp_valid_q;
  logic              run;
  logic              grant1;
  logic              handshake;

  assign run = (state_q == ST_RUN);

  // rr_q holds the last winner; on a tie the other port wins.
  assign grant1    = req1_valid && (!req0_valid || !rr_q);
  assign handshake = run && (req0_valid || req1_valid) && !clear_req;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_WAIT;
      init_cnt_q   <= '0;
      rr_q         <= 1'b1;
      resp_valid_q <= 2'b00;
    end else begin
      state_q <= state_d;
      // Counter wraps to 0 at the end of INIT, ready for the next clear.
      if (state_q == ST_INIT) begin
        init_cnt_q <= init_cnt_q + 1'b1;
      end
      if (handshake) begin
        rr_q <= grant1;
      end
      resp_valid_q[0] <= handshake && !grant1 && !req0_wmode;
      resp_valid_q[1] <= handshake && grant1 && !req1_wmode;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT: state_d = ST_INIT;
      ST_INIT: if (init_cnt_q == CNT_LAST) state_d = ST_RUN;
      ST_RUN:  if (clear_req) state_d = ST_INIT;
      default: state_d = ST_WAIT;
    endcase
  end

  always_comb begin
    init_done  = run;
    req0_ready = handshake && !grant1;
    req1_ready = handshake && grant1;
    mem_en     = 1'b0;
    mem_wmode  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (state_q == ST_INIT) begin
      mem_en    = 1'b1;
      mem_wmode = 1'b1;
      mem_addr  = init_cnt_q;
    end else if (handshake) begin
      mem_en    = 1'b1;
      mem_wmode = grant1 ? req1_wmode : req0_wmode;
      mem_addr  = grant1 ? req1_addr  : req0_addr;
      mem_wdata = grant1 ? req1_wdata : req0_wdata;
    end
  end

  assign resp0_valid = resp_valid_q[0];
  assign resp1_valid = resp_valid_q[1];
  assign resp0_data  = mem_rdata;
  assign resp1_data  = mem_rdata;

`ifdef SRAM_RR_ARB_CONFLICT_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      conflict_cnt <= '0;
    end else if (run && clear_req) begin
      conflict_cnt <= '0;
    end else if (run && req0_valid && req1_valid && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule
